// File: rtl/bsg_mem_2r1w_sync_sched_pkg.sv
// Shared types for the 2r1w synchronous RAM request scheduler.
package bsg_mem_2r1w_sync_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } bsg_mem_sched_rport_state_e;

    localparam int unsigned StallCntWidth = 4;

endpackage

// File: rtl/bsg_mem_2r1w_sync_sched_rport.sv
// One read port of the scheduler: request acceptance, response FSM and skid register.
module bsg_mem_2r1w_sync_sched_rport
    import bsg_mem_2r1w_sync_sched_pkg::*;
#(
    parameter int unsigned width_p      = 8,
    parameter int unsigned addr_width_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic                    lose_i,
    input  logic                    yumi_i,
    input  logic [width_p-1:0]      mem_data_i,
    output logic                    slot_free_o,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    output logic                    mem_v_o,
    output logic [addr_width_p-1:0] mem_addr_o
);

    bsg_mem_sched_rport_state_e state_q, state_d;
    logic [width_p-1:0]         skid_q, skid_d;
    logic                       accept;

    always_comb begin
        slot_free_o = (state_q == IDLE) | yumi_i;
        ready_o     = slot_free_o & ~lose_i;
        accept      = v_i & ready_o;
        mem_v_o     = accept;
        mem_addr_o  = addr_i;
        v_o         = (state_q != IDLE);

        case (state_q)
            PEND:    data_o = mem_data_i;
            HOLD:    data_o = skid_q;
            default: data_o = '0;
        endcase

        state_d = state_q;
        skid_d  = skid_q;
        if (accept) begin
            state_d = PEND;
        end else begin
            case (state_q)
                PEND: begin
                    // RAM data is only valid for one cycle; capture it if not consumed.
                    if (yumi_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        skid_d  = mem_data_i;
                    end
                end
                HOLD:    if (yumi_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/bsg_mem_2r1w_sync_sched.sv
// Scheduler in front of a 2r1w sync RAM that never reads and writes one address in a cycle.
// Define BSG_MEM_2R1W_SYNC_SCHED_PERF_EN to enable the saturating conflict_cnt_o counter.
module bsg_mem_2r1w_sync_sched
    import bsg_mem_2r1w_sync_sched_pkg::*;
#(
    parameter int unsigned width_p       = 8,
    parameter int unsigned els_p         = 16,
    parameter int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    parameter int unsigned write_first_p = 1,
    parameter int unsigned max_stall_p   = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    output logic                     w_ready_o,

    input  logic                     r0_v_i,
    input  logic [addr_width_lp-1:0] r0_addr_i,
    output logic                     r0_ready_o,
    output logic                     r0_v_o,
    output logic [width_p-1:0]       r0_data_o,
    input  logic                     r0_yumi_i,

    input  logic                     r1_v_i,
    input  logic [addr_width_lp-1:0] r1_addr_i,
    output logic                     r1_ready_o,
    output logic                     r1_v_o,
    output logic [width_p-1:0]       r1_data_o,
    input  logic                     r1_yumi_i,

    output logic                     mem_w_v_o,
    output logic [addr_width_lp-1:0] mem_w_addr_o,
    output logic [width_p-1:0]       mem_w_data_o,
    output logic                     mem_r0_v_o,
    output logic [addr_width_lp-1:0] mem_r0_addr_o,
    input  logic [width_p-1:0]       mem_r0_data_i,
    output logic                     mem_r1_v_o,
    output logic [addr_width_lp-1:0] mem_r1_addr_o,
    input  logic [width_p-1:0]       mem_r1_data_i,

    output logic [31:0]              conflict_cnt_o
);

    localparam logic                     WriteFirst = (write_first_p != 0);
    localparam logic [StallCntWidth-1:0] MaxStall   = StallCntWidth'(max_stall_p);

    logic [StallCntWidth-1:0] stall_q, stall_d;
    logic slot_free0, slot_free1;
    logic conflict0, conflict1, conflict_any;
    logic flip, write_wins, write_lose, lose0, lose1;

    always_comb begin
        conflict0    = w_v_i & r0_v_i & slot_free0 & (w_addr_i == r0_addr_i);
        conflict1    = w_v_i & r1_v_i & slot_free1 & (w_addr_i == r1_addr_i);
        conflict_any = conflict0 | conflict1;
        flip         = (stall_q == MaxStall);
        // A single winner decision covers both read ports.
        write_wins   = WriteFirst ^ flip;
        write_lose   = conflict_any & ~write_wins;
        // Reset forces every request to lose so no RAM enable leaks out.
        lose0        = (conflict0 & write_wins) | reset_i;
        lose1        = (conflict1 & write_wins) | reset_i;

        w_ready_o    = ~write_lose & ~reset_i;
        mem_w_v_o    = w_v_i & w_ready_o;
        mem_w_addr_o = w_addr_i;
        mem_w_data_o = w_data_i;

        if (flip)              stall_d = '0;
        else if (conflict_any) stall_d = stall_q + 1'b1;
        else                   stall_d = '0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) stall_q <= '0;
        else         stall_q <= stall_d;
    end

    bsg_mem_2r1w_sync_sched_rport #(
        .width_p      (width_p),
        .addr_width_p (addr_width_lp)
    ) u_rport0 (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .v_i         (r0_v_i),
        .addr_i      (r0_addr_i),
        .lose_i      (lose0),
        .yumi_i      (r0_yumi_i),
        .mem_data_i  (mem_r0_data_i),
        .slot_free_o (slot_free0),
        .ready_o     (r0_ready_o),
        .v_o         (r0_v_o),
        .data_o      (r0_data_o),
        .mem_v_o     (mem_r0_v_o),
        .mem_addr_o  (mem_r0_addr_o)
    );

    bsg_mem_2r1w_sync_sched_rport #(
        .width_p      (width_p),
        .addr_width_p (addr_width_lp)
    ) u_rport1 (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .v_i         (r1_v_i),
        .addr_i      (r1_addr_i),
        .lose_i      (lose1),
        .yumi_i      (r1_yumi_i),
        .mem_data_i  (mem_r1_data_i),
        .slot_free_o (slot_free1),
        .ready_o     (r1_ready_o),
        .v_o         (r1_v_o),
        .data_o      (r1_data_o),
        .mem_v_o     (mem_r1_v_o),
        .mem_addr_o  (mem_r1_addr_o)
    );

`ifdef BSG_MEM_2R1W_SYNC_SCHED_PERF_EN
    logic [31:0] conflict_cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                                conflict_cnt_q <= '0;
        else if (conflict_any && ~&conflict_cnt_q) conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end

    assign conflict_cnt_o = conflict_cnt_q;
`else
    assign conflict_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    localparam logic [addr_width_lp:0] ElsLim = (addr_width_lp + 1)'(els_p);

    a_w_addr:  assert property (@(posedge clk_i) disable iff (reset_i)
                                w_v_i |-> ({1'b0, w_addr_i} < ElsLim));
    a_r0_addr: assert property (@(posedge clk_i) disable iff (reset_i)
                                r0_v_i |-> ({1'b0, r0_addr_i} < ElsLim));
    a_r1_addr: assert property (@(posedge clk_i) disable iff (reset_i)
                                r1_v_i |-> ({1'b0, r1_addr_i} < ElsLim));
`endif

endmodule

// File: tb/tb_bsg_mem_2r1w_sync_sched.sv
// Self-checking bench for bsg_mem_2r1w_sync_sched with a 2r1w sync RAM model and scoreboard.
module tb_bsg_mem_2r1w_sync_sched;

    localparam int W = 16;
    localparam int E = 16;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         w_v_i, r0_v_i, r1_v_i, r0_yumi_i, r1_yumi_i;
    logic [A-1:0] w_addr_i, r0_addr_i, r1_addr_i;
    logic [W-1:0] w_data_i;
    logic         w_ready_o, r0_ready_o, r1_ready_o, r0_v_o, r1_v_o;
    logic [W-1:0] r0_data_o, r1_data_o;
    logic         mem_w_v_o, mem_r0_v_o, mem_r1_v_o;
    logic [A-1:0] mem_w_addr_o, mem_r0_addr_o, mem_r1_addr_o;
    logic [W-1:0] mem_w_data_o, mem_r0_data_i, mem_r1_data_i;
    logic [31:0]  conflict_cnt_o;

    logic         ram_init = 1'b0;
    logic [W-1:0] ram [E];
    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];
    logic [W-1:0] e0, e1;
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    bsg_mem_2r1w_sync_sched #(
        .width_p       (W),
        .els_p         (E),
        .write_first_p (1),
        .max_stall_p   (2)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .w_v_i          (w_v_i),
        .w_addr_i       (w_addr_i),
        .w_data_i       (w_data_i),
        .w_ready_o      (w_ready_o),
        .r0_v_i         (r0_v_i),
        .r0_addr_i      (r0_addr_i),
        .r0_ready_o     (r0_ready_o),
        .r0_v_o         (r0_v_o),
        .r0_data_o      (r0_data_o),
        .r0_yumi_i      (r0_yumi_i),
        .r1_v_i         (r1_v_i),
        .r1_addr_i      (r1_addr_i),
        .r1_ready_o     (r1_ready_o),
        .r1_v_o         (r1_v_o),
        .r1_data_o      (r1_data_o),
        .r1_yumi_i      (r1_yumi_i),
        .mem_w_v_o      (mem_w_v_o),
        .mem_w_addr_o   (mem_w_addr_o),
        .mem_w_data_o   (mem_w_data_o),
        .mem_r0_v_o     (mem_r0_v_o),
        .mem_r0_addr_o  (mem_r0_addr_o),
        .mem_r0_data_i  (mem_r0_data_i),
        .mem_r1_v_o     (mem_r1_v_o),
        .mem_r1_addr_o  (mem_r1_addr_o),
        .mem_r1_data_i  (mem_r1_data_i),
        .conflict_cnt_o (conflict_cnt_o)
    );

    // RAM model; unread cycles return 0xFxxx garbage so stale data is visible.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < E; i++) ram[i] <= 16'h1000 + 16'(i);
        end else if (mem_w_v_o) begin
            ram[mem_w_addr_o] <= mem_w_data_o;
        end
        mem_r0_data_i <= mem_r0_v_o ? ram[mem_r0_addr_o] : (16'hF000 | 16'($urandom_range(0, 4095)));
        mem_r1_data_i <= mem_r1_v_o ? ram[mem_r1_addr_o] : (16'hF000 | 16'($urandom_range(0, 4095)));
    end

    // Scoreboard: pop on every consumed response.
    always @(negedge clk) begin
        if (!reset_i && r0_v_o && r0_yumi_i) begin
            n_vec++;
            if (exp0_q.size() == 0) begin
                n_err++; $display("FAIL r0_resp unexpected: got %h, expected none", r0_data_o);
            end else begin
                e0 = exp0_q.pop_front();
                if (r0_data_o !== e0) begin
                    n_err++; $display("FAIL r0_resp: got %h, expected %h", r0_data_o, e0);
                end
            end
        end
        if (!reset_i && r1_v_o && r1_yumi_i) begin
            n_vec++;
            if (exp1_q.size() == 0) begin
                n_err++; $display("FAIL r1_resp unexpected: got %h, expected none", r1_data_o);
            end else begin
                e1 = exp1_q.pop_front();
                if (r1_data_o !== e1) begin
                    n_err++; $display("FAIL r1_resp: got %h, expected %h", r1_data_o, e1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        w_v_i = 0; w_addr_i = '0; w_data_i = '0;
        r0_v_i = 0; r0_addr_i = '0; r0_yumi_i = 1;
        r1_v_i = 0; r1_addr_i = '0; r1_yumi_i = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_i = 1; ram_init = 1;
        tick();
        ram_init = 0;
        @(negedge clk);
        n_vec++; if (r0_v_o !== 1'b0) begin n_err++; $display("FAIL reset r0_v_o: got %b, expected 0", r0_v_o); end
        n_vec++; if (r1_v_o !== 1'b0) begin n_err++; $display("FAIL reset r1_v_o: got %b, expected 0", r1_v_o); end
        n_vec++; if (r0_data_o !== 16'h0) begin n_err++; $display("FAIL reset r0_data_o: got %h, expected 0", r0_data_o); end
        n_vec++; if (conflict_cnt_o !== 32'd0) begin n_err++; $display("FAIL reset conflict_cnt: got %0d, expected 0", conflict_cnt_o); end
        tick();
        reset_i = 0;
        @(negedge clk);
        n_vec++; if (w_ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset w_ready: got %b, expected 1", w_ready_o); end
        n_vec++; if (r0_ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset r0_ready: got %b, expected 1", r0_ready_o); end
        n_vec++; if (r1_ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset r1_ready: got %b, expected 1", r1_ready_o); end
        n_vec++; if (mem_r0_v_o !== 1'b0) begin n_err++; $display("FAIL post_reset mem_r0_v: got %b, expected 0", mem_r0_v_o); end
        tick();
    endtask

    task automatic test_read_basic();
        r0_v_i = 1; r0_addr_i = 4'd3; exp0_q.push_back(16'h1003);
        @(negedge clk);
        n_vec++; if (mem_r0_v_o !== 1'b1 || mem_r0_addr_o !== 4'd3) begin
            n_err++; $display("FAIL basic mem_r0: got v=%b a=%0d, expected v=1 a=3", mem_r0_v_o, mem_r0_addr_o);
        end
        tick();
        r0_v_i = 0;
        @(negedge clk);
        n_vec++; if (r0_v_o !== 1'b1) begin n_err++; $display("FAIL basic r0_v_o: got %b, expected 1", r0_v_o); end
        tick();
        @(negedge clk);
        n_vec++; if (r0_v_o !== 1'b0) begin n_err++; $display("FAIL basic idle r0_v_o: got %b, expected 0", r0_v_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            r0_v_i = 1; r0_addr_i = (i == 4) ? 4'd6 : A'(i);
            r1_v_i = 1; r1_addr_i = (i == 4) ? 4'd6 : A'(8 + i);
            exp0_q.push_back(16'h1000 + 16'(r0_addr_i));
            exp1_q.push_back(16'h1000 + 16'(r1_addr_i));
            @(negedge clk);
            n_vec++; if (r0_ready_o !== 1'b1 || r1_ready_o !== 1'b1) begin
                n_err++; $display("FAIL b2b ready[%0d]: got %b%b, expected 11", i, r0_ready_o, r1_ready_o);
            end
            tick();
        end
        idle_inputs();
        tick(); tick();
        n_vec++; if (exp0_q.size() + exp1_q.size() != 0) begin
            n_err++; $display("FAIL b2b drain: got %0d pending, expected 0", exp0_q.size() + exp1_q.size());
        end
    endtask

    task automatic test_write_first();
        w_v_i = 1; w_addr_i = 4'd5; w_data_i = 16'hBEEF;
        r0_v_i = 1; r0_addr_i = 4'd5;
        @(negedge clk);
        n_vec++; if (mem_w_v_o !== 1'b1 || w_ready_o !== 1'b1) begin
            n_err++; $display("FAIL wfirst write: got v=%b rdy=%b, expected 1 1", mem_w_v_o, w_ready_o);
        end
        n_vec++; if (r0_ready_o !== 1'b0 || mem_r0_v_o !== 1'b0) begin
            n_err++; $display("FAIL wfirst read stall: got rdy=%b v=%b, expected 0 0", r0_ready_o, mem_r0_v_o);
        end
        tick();
        w_v_i = 0;
        exp0_q.push_back(16'hBEEF);
        @(negedge clk);
        n_vec++; if (r0_ready_o !== 1'b1 || mem_r0_v_o !== 1'b1) begin
            n_err++; $display("FAIL wfirst read issue: got rdy=%b v=%b, expected 1 1", r0_ready_o, mem_r0_v_o);
        end
        tick();
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_starvation();
        w_v_i = 1; w_addr_i = 4'd7; w_data_i = 16'h7777;
        r1_v_i = 1; r1_addr_i = 4'd7;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) exp1_q.push_back(16'h7777);
            @(negedge clk);
            n_vec++; if (w_ready_o !== (c != 3) || r1_ready_o !== (c == 3)) begin
                n_err++; $display("FAIL starve cycle %0d: got w_rdy=%b r1_rdy=%b, expected %b %b",
                                  c, w_ready_o, r1_ready_o, c != 3, c == 3);
            end
            tick();
        end
        r1_v_i = 0;
        @(negedge clk);
        n_vec++; if (w_ready_o !== 1'b1) begin n_err++; $display("FAIL starve recover w_rdy: got %b, expected 1", w_ready_o); end
        tick();
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_hold();
        r0_yumi_i = 0; r0_v_i = 1; r0_addr_i = 4'd9; exp0_q.push_back(16'h1009);
        tick();
        r0_v_i = 0;
        @(negedge clk);
        n_vec++; if (r0_v_o !== 1'b1 || r0_data_o !== 16'h1009) begin
            n_err++; $display("FAIL hold pend: got v=%b d=%h, expected 1 1009", r0_v_o, r0_data_o);
        end
        tick();
        r0_v_i = 1; r0_addr_i = 4'd10;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_vec++; if (r0_data_o !== 16'h1009) begin
                n_err++; $display("FAIL hold data[%0d]: got %h, expected 1009", c, r0_data_o);
            end
            n_vec++; if (r0_ready_o !== 1'b0 || mem_r0_v_o !== 1'b0) begin
                n_err++; $display("FAIL hold blocked[%0d]: got rdy=%b v=%b, expected 0 0", c, r0_ready_o, mem_r0_v_o);
            end
            tick();
        end
        r0_yumi_i = 1; exp0_q.push_back(16'h100A);
        @(negedge clk);
        n_vec++; if (r0_ready_o !== 1'b1 || mem_r0_v_o !== 1'b1) begin
            n_err++; $display("FAIL hold yumi accept: got rdy=%b v=%b, expected 1 1", r0_ready_o, mem_r0_v_o);
        end
        tick();
        idle_inputs();
        tick(); tick();
        n_vec++; if (exp0_q.size() != 0) begin n_err++; $display("FAIL hold drain: got %0d pending, expected 0", exp0_q.size()); end
    endtask

    task automatic test_reset_mid();
        r1_yumi_i = 0; r1_v_i = 1; r1_addr_i = 4'd2; exp1_q.push_back(16'h1002);
        tick();
        r1_v_i = 0;
        r0_yumi_i = 0; r0_v_i = 1; r0_addr_i = 4'd4; exp0_q.push_back(16'h1004);
        tick();
        @(negedge clk);
        n_vec++; if (r0_v_o !== 1'b1 || r1_v_o !== 1'b1 || r1_data_o !== 16'h1002) begin
            n_err++; $display("FAIL midreset pre: got v0=%b v1=%b d1=%h, expected 1 1 1002", r0_v_o, r1_v_o, r1_data_o);
        end
        #2;
        reset_i = 1;
        exp0_q.delete(); exp1_q.delete();
        #1;
        n_vec++; if (r0_v_o !== 1'b0 || r1_v_o !== 1'b0) begin
            n_err++; $display("FAIL midreset v_o: got %b%b, expected 00", r0_v_o, r1_v_o);
        end
        n_vec++; if (mem_r0_v_o !== 1'b0 || mem_w_v_o !== 1'b0) begin
            n_err++; $display("FAIL midreset mem enables: got r0=%b w=%b, expected 0 0", mem_r0_v_o, mem_w_v_o);
        end
        n_vec++; if (conflict_cnt_o !== 32'd0) begin n_err++; $display("FAIL midreset cnt: got %0d, expected 0", conflict_cnt_o); end
        tick();
        idle_inputs();
        reset_i = 0;
        tick();
        @(negedge clk);
        n_vec++; if (r0_v_o !== 1'b0 || r1_v_o !== 1'b0) begin
            n_err++; $display("FAIL midreset after: got %b%b, expected 00", r0_v_o, r1_v_o);
        end
        tick();
    endtask

    task automatic test_perf();
        logic [31:0] exp_cnt;
`ifdef BSG_MEM_2R1W_SYNC_SCHED_PERF_EN
        exp_cnt = 32'd10;
`else
        exp_cnt = 32'd0;
`endif
        w_v_i = 1; w_addr_i = 4'd1; w_data_i = 16'h5555;
        r0_v_i = 1; r0_addr_i = 4'd1;
        for (int c = 1; c <= 10; c++) begin
            if (c % 3 == 0) exp0_q.push_back(16'h5555);
            @(negedge clk);
            n_vec++; if (w_ready_o !== (c % 3 != 0) || r0_ready_o !== (c % 3 == 0)) begin
                n_err++; $display("FAIL perf cycle %0d: got w_rdy=%b r0_rdy=%b", c, w_ready_o, r0_ready_o);
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        n_vec++; if (conflict_cnt_o !== exp_cnt) begin
            n_err++; $display("FAIL perf conflict_cnt: got %0d, expected %0d", conflict_cnt_o, exp_cnt);
        end
        tick(); tick();
        n_vec++; if (exp0_q.size() != 0) begin n_err++; $display("FAIL perf drain: got %0d pending, expected 0", exp0_q.size()); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_read_basic();
        test_back_to_back();
        test_write_first();
        test_starvation();
        test_hold();
        test_reset_mid();
        test_perf();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bsg_mem_2r1w_sync_sched.md
Name: bsg_mem_2r1w_sync_sched

Overview:
Request scheduler in front of a 2-read/1-write synchronous RAM that forbids a read and a write to the same address in one cycle.
- Accepts one write stream and two read streams, each with valid/ready.
- Resolves same-address read/write conflicts by stalling the losing side.
- Buffers 1-cycle-late read data in per-port skid registers under valid/yumi.
- Lets register-file and tag-array clients use the hardened 2r1w macro without external hazard logic.

Parameters:
width_p, none (must set), data width.
els_p, none (must set), RAM entries.
addr_width_lp, `BSG_SAFE_CLOG2(els_p), address width.
write_first_p, 1, conflict winner at reset of the starvation counter: 1 write, 0 read.
max_stall_p, 4, consecutive lost conflicts before priority flips for one cycle; range 1..15.

Ports:
clk_i  in  1  clock
reset_i  in  1  async active-high reset
w_v_i / w_addr_i / w_data_i  in  1 / addr_width_lp / width_p  write request
w_ready_o  out  1  write accepted when w_v_i & w_ready_o
r0_v_i / r0_addr_i  in  1 / addr_width_lp  port-0 read request
r0_ready_o  out  1  port-0 read accepted
r0_v_o / r0_data_o  out  1 / width_p  port-0 read response
r0_yumi_i  in  1  port-0 response consumed
r1_v_i, r1_addr_i, r1_ready_o, r1_v_o, r1_data_o, r1_yumi_i  as for port 0
mem_w_v_o / mem_w_addr_o / mem_w_data_o  out  1 / addr_width_lp / width_p  RAM write port
mem_r0_v_o / mem_r0_addr_o  out  1 / addr_width_lp  RAM read port 0
mem_r0_data_i  in  width_p  RAM read data 0
mem_r1_v_o, mem_r1_addr_o, mem_r1_data_i  as for port 0
conflict_cnt_o  out  32  conflict count (see Optional Feature)

Behaviour:
- Clock clk_i; reset_i is asynchronous and active-high. All flops clear on reset assertion: ports to IDLE, stall counters 0, priority = write_first_p. After reset: all *_v_o = 0, data outputs 0, ready outputs combinational from state.
- Read-port FSM, per port k:
  - IDLE: no data outstanding.
  - PEND: RAM read issued last cycle; rk_v_o=1, rk_data_o = mem_rk_data_i.
  - HOLD: data in skid register; rk_v_o=1, rk_data_o = skid.
- Port slot free = IDLE, or (PEND|HOLD) & rk_yumi_i.
- rk_ready_o = slot free & ~lose_k.
- Read accept = rk_v_i & rk_ready_o. It drives mem_rk_v_o=1 and mem_rk_addr_o=rk_addr_i in the same cycle. Next state: PEND.
- Transitions:
  - PEND & ~yumi & no accept -> HOLD, skid <= mem_rk_data_i.
  - PEND | HOLD with yumi & no accept -> IDLE.
  - HOLD & ~yumi -> HOLD.
- Latency: request accept to rk_v_o is 1 cycle. Throughput is 1 read/port/cycle when yumi is held high.
- Conflict_k = w_v_i & rk_v_i & slot free & (w_addr_i == rk_addr_i).
  - Write wins: lose_k=1, write issues.
  - Read wins: w_ready_o=0 when either port's conflict is lost by the write.
- w_ready_o = ~(write loses any conflict). Write accept drives mem_w_* combinationally in the same cycle.
- Starvation control:
  - Counter increments on every cycle where the non-priority side loses a conflict.
  - Counter clears on any cycle without a conflict.
  - At max_stall_p, priority inverts for exactly one cycle, then the counter clears and priority returns to write_first_p.
- Both read ports conflicting with the write: one decision applies to both ports.
- Reads to the same address on r0 and r1: no conflict; both issue.
- Mid-operation reset: outstanding responses are dropped and no RAM enables are asserted.
- Address >= els_p is illegal; simulation assertion only.
- mem_*_v_o never asserts when its request is not accepted.

Optional Feature:
BSG_MEM_2R1W_SYNC_SCHED_PERF_EN
- Defined: conflict_cnt_o is a saturating 32-bit count of cycles with at least one conflict. It clears on reset.
- Undefined: conflict_cnt_o is tied to 0 and no counter flops exist.

Decomposition:
- Package bsg_mem_2r1w_sync_sched_pkg holds:
  - enum bsg_mem_sched_rport_state_e {IDLE, PEND, HOLD}.
  - Localparam for the 4-bit stall-counter width.
- Sub-module bsg_mem_2r1w_sync_sched_rport: per-port FSM plus skid register, instantiated twice.
- Conflict/priority logic stays in the top level.

Test Plan:
- Reset, then read r0 addr 3 with yumi held 1 -> r0_v_o high next cycle with RAM word 3; state returns to IDLE.
- Write addr 5 and r0 addr 5 in the same cycle, write_first_p=1 -> mem_w_v_o=1, r0_ready_o=0, mem_r0_v_o=0; read issues next cycle and returns the new data.
- write_first_p=1, max_stall_p=2, read r1 held on addr 7 while writes to addr 7 are held -> read stalls 2 cycles, wins on the 3rd with w_ready_o=0.
- r0 read with yumi low 3 cycles -> HOLD, r0_data_o stable while mem_r0_data_i changes; next read accepted only in the yumi cycle.
- Assert reset_i asynchronously while r0 is PEND and r1 is HOLD -> r0_v_o=r1_v_o=0 immediately, counters 0.
- PERF_EN defined: 10 conflicting cycles -> conflict_cnt_o=10; undefined -> 0.
